// File: rtl/tdc_pkg.sv
// Shared types for the TDC pulse generator: source/bypass selects, FSM states
// and a packed control-line status word for logging.
package tdc_pkg;

    typedef enum logic [1:0] {
        PG_IN     = 2'd0,
        PG_TOG    = 2'd1,
        PG_BURST  = 2'd2,
        PG_SINGLE = 2'd3
    } ctrl_pulse_src_t;

    typedef enum logic {
        BYPASS = 1'b0,
        REG    = 1'b1
    } ctrl_bypass_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIGH   = 2'd1,
        LOW    = 2'd2,
        TOGGLE = 2'd3
    } pg_state_t;

    localparam int          PULSE_CNT_W   = 16;
    localparam logic [15:0] PULSE_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        ctrl_pulse_src_t pls_src;
        ctrl_bypass_t    bypass;
        logic            busy;
        logic            done;
        logic            pulse_out;
    } ctl_line_status_t;

    // Packs the control lines into one word so a log line can show them together.
    function automatic ctl_line_status_t print_ctl_line_status(
        input ctrl_pulse_src_t pls_src,
        input ctrl_bypass_t    bypass,
        input logic            busy,
        input logic            done,
        input logic            pulse_out
    );
        ctl_line_status_t s;
        s.pls_src   = pls_src;
        s.bypass    = bypass;
        s.busy      = busy;
        s.done      = done;
        s.pulse_out = pulse_out;
        return s;
    endfunction

endpackage

// File: rtl/tdc_pg_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// One instance times the HIGH, LOW and TOGGLE intervals of the pulse generator.
module tdc_pg_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/tdc_pulse_gen.sv
// Pulse generator: external pass-through, free-running toggle, burst and single modes.
// Define TDC_PG_PULSE_CNT_EN to build the saturating pulse_out rising-edge counter.
module tdc_pulse_gen
    import tdc_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         pls_src,
    input  logic               bypass,
    input  logic               pulse_in,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   period,
    input  logic [BURST_W-1:0] burst_len,
    output logic               pulse_out,
    output logic               busy,
    output logic               done,
    output logic [15:0]        pulse_cnt
);

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    ctrl_pulse_src_t    src;
    pg_state_t          state_q, state_d;
    ctrl_pulse_src_t    mode_q, mode_d;
    logic [CNT_W-1:0]   pm1_q, pm1_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               lvl_q, lvl_d;
    logic               done_q, done_d;
    logic               pin_q;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_expired;
    logic [CNT_W-1:0]   p_eff_m1;
    logic               gen_pulse;

    assign src = ctrl_pulse_src_t'(pls_src);

    // Interval length minus one, with period 0 treated as 1.
    assign p_eff_m1 = (period == '0) ? '0 : (period - CNT_ONE);

    tdc_pg_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        pm1_d    = pm1_q;
        rem_d    = rem_q;
        lvl_d    = lvl_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: begin
                if (start && !stop && (src != PG_IN)) begin
                    mode_d   = src;
                    pm1_d    = p_eff_m1;
                    rem_d    = burst_len;
                    tmr_load = 1'b1;
                    case (src)
                        PG_TOG: begin
                            state_d = TOGGLE;
                            lvl_d   = 1'b1;
                            tmr_val = p_eff_m1;
                        end
                        PG_BURST: begin
                            state_d = HIGH;
                            tmr_val = '0;
                        end
                        default: begin
                            state_d = HIGH;
                            tmr_val = p_eff_m1;
                        end
                    endcase
                end
            end
            HIGH: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tmr_expired) begin
                    // Burst pulses still owed go through a LOW gap; the last one ends the job.
                    if ((mode_q == PG_BURST) && (rem_q != '0)) begin
                        rem_d    = rem_q - BURST_ONE;
                        state_d  = LOW;
                        tmr_load = 1'b1;
                        tmr_val  = pm1_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            LOW: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tmr_expired) begin
                    state_d  = HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = '0;
                end
            end
            TOGGLE: begin
                if (stop) begin
                    state_d = IDLE;
                    lvl_d   = 1'b0;
                end else if (tmr_expired) begin
                    lvl_d    = ~lvl_q;
                    tmr_load = 1'b1;
                    tmr_val  = pm1_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= PG_IN;
            pm1_q   <= '0;
            rem_q   <= '0;
            lvl_q   <= 1'b0;
            done_q  <= 1'b0;
            pin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pm1_q   <= pm1_d;
            rem_q   <= rem_d;
            lvl_q   <= lvl_d;
            done_q  <= done_d;
            pin_q   <= pulse_in;
        end
    end

    assign gen_pulse = (state_q == HIGH) || ((state_q == TOGGLE) && lvl_q);

    // The external path is only visible while no generated job owns the output.
    always_comb begin
        pulse_out = gen_pulse;
        if ((state_q == IDLE) && (src == PG_IN)) begin
            pulse_out = (bypass == BYPASS) ? pulse_in : pin_q;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

`ifdef TDC_PG_PULSE_CNT_EN
    logic [PULSE_CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic                   pulse_prev_q;

    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        if (pulse_out && !pulse_prev_q && (pulse_cnt_q != PULSE_CNT_MAX)) begin
            pulse_cnt_d = pulse_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_cnt_q  <= '0;
            pulse_prev_q <= 1'b0;
        end else begin
            pulse_cnt_q  <= pulse_cnt_d;
            pulse_prev_q <= pulse_out;
        end
    end

    assign pulse_cnt = pulse_cnt_q;
`else
    assign pulse_cnt = '0;
`endif

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Self-checking bench for tdc_pulse_gen: a per-job timing model checked every cycle,
// plus directed scenarios pinned with hand-computed waveforms.
module tb_tdc_pulse_gen;
    import tdc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pls_src;
    logic        bypass;
    logic        pulse_in;
    logic        start;
    logic        stop;
    logic [7:0]  period;
    logic [3:0]  burst_len;
    logic        pulse_out;
    logic        busy;
    logic        done;
    logic [15:0] pulse_cnt;

    always #5 clk = ~clk;

    tdc_pulse_gen #(
        .CNT_W   (8),
        .BURST_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pls_src   (pls_src),
        .bypass    (bypass),
        .pulse_in  (pulse_in),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .burst_len (burst_len),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit checking = 1'b0;

    // Model of the one job that may be in flight: launch cycle, mode, P, pulse count.
    bit              job_act = 1'b0;
    ctrl_pulse_src_t job_mode = PG_TOG;
    int              job_ts = 0;
    int              job_p  = 1;
    int              job_nb = 1;
    bit              m_pin_q = 1'b0;
    bit              m_prev  = 1'b0;
    int              m_cnt   = 0;

    function automatic int last_busy_k();
        if (job_mode == PG_TOG)   return 32'h3FFF_FFFF;
        if (job_mode == PG_BURST) return 1 + (job_nb - 1) * (job_p + 1);
        return job_p;
    endfunction

    function automatic bit job_busy(input int c);
        int k;
        k = c - job_ts;
        return job_act && (k >= 1) && (k <= last_busy_k());
    endfunction

    function automatic bit job_high(input int c);
        int k;
        k = c - job_ts;
        if (job_mode == PG_TOG)   return (((k - 1) / job_p) % 2) == 0;
        if (job_mode == PG_BURST) return ((k - 1) % (job_p + 1)) == 0;
        return 1'b1;
    endfunction

    function automatic bit job_done(input int c);
        return job_act && (job_mode != PG_TOG) && ((c - job_ts) == last_busy_k() + 1);
    endfunction

    function automatic bit exp_pulse(input int c);
        if (job_busy(c)) return job_high(c);
        if (pls_src == PG_IN) return (bypass == BYPASS) ? pulse_in : m_pin_q;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Model update at each active edge; inputs are stable here (driven #1 after the edge).
    initial begin
        bit e;
        forever begin
            @(posedge clk);
            e = exp_pulse(cyc);
            cyc++;
            if (rst) begin
                job_act = 1'b0;
                m_pin_q = 1'b0;
                m_prev  = 1'b0;
                m_cnt   = 0;
            end else begin
                if (e && !m_prev && (m_cnt != 65535)) m_cnt++;
                m_prev = e;
                if (job_busy(cyc - 1)) begin
                    if (stop) job_act = 1'b0;
                end else if (start && !stop && (pls_src != PG_IN)) begin
                    job_act  = 1'b1;
                    job_mode = ctrl_pulse_src_t'(pls_src);
                    job_ts   = cyc - 1;
                    job_p    = (period == 8'd0) ? 1 : int'(period);
                    job_nb   = int'(burst_len) + 1;
                end
                m_pin_q = pulse_in;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                chk("pulse_out", {31'd0, pulse_out}, {31'd0, exp_pulse(cyc)});
                chk("busy",      {31'd0, busy},      {31'd0, job_busy(cyc)});
                chk("done",      {31'd0, done},      {31'd0, job_done(cyc)});
`ifdef TDC_PG_PULSE_CNT_EN
                chk("pulse_cnt", {16'd0, pulse_cnt}, 32'(m_cnt));
`else
                chk("pulse_cnt", {16'd0, pulse_cnt}, 32'd0);
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic capture(input int n, output logic [31:0] pv, output logic [31:0] bv,
                           output logic [31:0] dv);
        pv = '0;
        bv = '0;
        dv = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pv[i] = pulse_out;
            bv[i] = busy;
            dv[i] = done;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (n < max) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        if (n >= max) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout cyc=%0d busy=%0b expected busy=0", cyc, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic log_txn(input string nm);
        $display("txn %-12s cyc=%0d status=%h cnt=%h", nm, cyc,
                 print_ctl_line_status(ctrl_pulse_src_t'(pls_src), ctrl_bypass_t'(bypass),
                                       busy, done, pulse_out), pulse_cnt);
    endtask

    task automatic run_burst(input logic [7:0] p, input logic [3:0] n);
        pls_src   = PG_BURST;
        period    = p;
        burst_len = n;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
        wait_idle(200);
    endtask

    initial begin
        logic [31:0] pv, bv, dv;
        rst       = 1'b1;
        pls_src   = PG_TOG;
        bypass    = REG;
        pulse_in  = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        period    = 8'd0;
        burst_len = 4'd0;
        tick(1);
        checking = 1'b1;
        tick(2);
        rst = 1'b0;

        @(negedge clk);
        chk("reset_pulse", {31'd0, pulse_out}, 32'd0);
        chk("reset_busy",  {31'd0, busy},      32'd0);
        chk("reset_done",  {31'd0, done},      32'd0);
        chk("reset_cnt",   {16'd0, pulse_cnt}, 32'd0);
        @(posedge clk);
        #1;
        log_txn("reset");

        // Burst P=3, three pulses; params changed and start re-pulsed while busy.
        pls_src   = PG_BURST;
        period    = 8'd3;
        burst_len = 4'd2;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
        pls_src   = PG_SINGLE;
        period    = 8'd9;
        burst_len = 4'd7;
        fork
            capture(11, pv, bv, dv);
            begin
                tick(2);
                start = 1'b1;
                tick(3);
                start = 1'b0;
            end
        join
        chk("burst_pulse", pv, 32'h111);
        chk("burst_busy",  bv, 32'h1FF);
        chk("burst_done",  dv, 32'h200);
        log_txn("burst");

        // Single with period 0 (one cycle) and period 5.
        pls_src = PG_SINGLE;
        period  = 8'd0;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
        capture(3, pv, bv, dv);
        chk("single0_pulse", pv, 32'h1);
        chk("single0_done",  dv, 32'h2);
        period = 8'd5;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        capture(7, pv, bv, dv);
        chk("single5_pulse", pv, 32'h1F);
        chk("single5_busy",  bv, 32'h1F);
        chk("single5_done",  dv, 32'h20);
        log_txn("single");

        // Toggle P=2 then stop.
        pls_src = PG_TOG;
        period  = 8'd2;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
        capture(8, pv, bv, dv);
        chk("tog_pulse", pv, 32'h33);
        chk("tog_busy",  bv, 32'hFF);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        capture(3, pv, bv, dv);
        chk("tog_stop_pulse", pv, 32'h0);
        chk("tog_stop_busy",  bv, 32'h0);
        chk("tog_stop_done",  dv, 32'h0);
        log_txn("toggle_stop");

        // Stop while idle does nothing.
        stop = 1'b1;
        tick(2);
        stop = 1'b0;

        // External path: registered edge one cycle late, bypass edge same cycle.
        pls_src  = PG_IN;
        bypass   = REG;
        pulse_in = 1'b0;
        tick(2);
        pulse_in = 1'b1;
        start    = 1'b1;
        capture(3, pv, bv, dv);
        start    = 1'b0;
        chk("in_reg_pulse", pv, 32'h6);
        chk("in_reg_busy",  bv, 32'h0);
        pulse_in = 1'b0;
        tick(2);
        bypass   = BYPASS;
        pulse_in = 1'b1;
        capture(2, pv, bv, dv);
        chk("in_byp_pulse", pv, 32'h3);
        pulse_in = 1'b0;
        capture(1, pv, bv, dv);
        chk("in_byp_fall", pv, 32'h0);
        bypass = REG;
        tick(2);
        log_txn("pg_in");

        // Reset mid-burst, then start+stop together in idle.
        pls_src   = PG_BURST;
        period    = 8'd2;
        burst_len = 4'd5;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        capture(4, pv, bv, dv);
        chk("rst_pulse", pv, 32'h0);
        chk("rst_busy",  bv, 32'h0);
        chk("rst_done",  dv, 32'h0);
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        capture(3, pv, bv, dv);
        chk("startstop_busy", bv, 32'h0);
        chk("startstop_done", dv, 32'h0);
        log_txn("rst_abort");

        // Three bursts of four pulses after the reset above.
        for (int b = 0; b < 3; b++) run_burst(8'd1, 4'd3);
        @(negedge clk);
`ifdef TDC_PG_PULSE_CNT_EN
        chk("cnt_12", {16'd0, pulse_cnt}, 32'd12);
`else
        chk("cnt_tied0", {16'd0, pulse_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1;
        log_txn("cnt_bursts");

`ifdef TDC_PG_PULSE_CNT_EN
        #2;
        force dut.pulse_cnt_q = 16'hFFFD;
        m_cnt = 16'hFFFD;
        @(posedge clk);
        #1;
        release dut.pulse_cnt_q;
        run_burst(8'd1, 4'd3);
        @(negedge clk);
        chk("cnt_sat", {16'd0, pulse_cnt}, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        log_txn("cnt_sat");
`endif

        tick(2);
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
